moldudp64_tx_framer: RTL and testbench

// - Transmit-side counterpart of the ITCH/MoldUDP64 receive parser.
// - Serialises a 64-byte Eth/IPv4/UDP/MoldUDP64 header, followed by an optional ITCH payload, onto a 64-bit network word stream.
// - Feeds the MAC TX path and loops back to the parser in system benches.

---
 rtl/moldudp64_tx_framer.sv | 250 +++++++++++++++++++++++++
 tb/tb_moldudp64_tx_framer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/moldudp64_tx_framer.sv
// MoldUDP64 TX framer: 8-word Eth/IPv4/UDP/MoldUDP64 header then optional ITCH payload.
// Optional IPV4_CSUM_EN: compute the IPv4 header checksum instead of passing it through.
module moldudp64_tx_framer #(
    parameter int CNT_W        = 7,
    parameter int MAX_PL_WORDS = 119
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [511:0]     hdr_in,
    output logic             busy,
    input  logic [63:0]      pl_data,
    input  logic             pl_valid,
    output logic             pl_ready,
    input  logic             pl_last,
    input  logic [2:0]       pl_keep,
    output logic [63:0]      tx_data_net,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_last,
    output logic [2:0]       tx_keep,
    output logic [CNT_W-1:0] counterOut,
    output logic             done,
    output logic             trunc_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_PAYLOAD,
        S_DRAIN
    } state_t;

    localparam logic [CNT_W-1:0] MAX_PL = CNT_W'(MAX_PL_WORDS);

    state_t r_state;
    state_t w_next;

    logic [511:0]     r_hdr;
    logic [2:0]       r_widx;
    logic [63:0]      r_tx_data;
    logic             r_tx_valid;
    logic             r_tx_last;
    logic [2:0]       r_tx_keep;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_plcnt;
    logic             r_trunc_pend;
    logic             r_done;
    logic             r_trunc;

    logic [63:0]      w_word [8];
    logic [63:0]      w_hdr_word;
    logic             w_tx_fire;
    logic             w_pl_fire;
    logic             w_hb;
    logic             w_w7;
    logic             w_pl_ready;
    logic             w_cur_last;
    logic             w_trunc;
    logic [CNT_W-1:0] w_pl_num;
    logic [CNT_W-1:0] w_cnt_inc;

`ifdef IPV4_CSUM_EN
    logic [19:0] w_sum;
    logic [16:0] w_fold1;
    logic [16:0] w_fold2;
    logic [15:0] w_csum;

    always_comb begin
        w_sum = 20'(r_hdr[383:368]) + 20'(r_hdr[367:352])
              + 20'(r_hdr[351:336]) + 20'(r_hdr[335:320])
              + 20'(r_hdr[319:304]) + 20'(r_hdr[287:272])
              + 20'(r_hdr[271:256]) + 20'(r_hdr[255:240])
              + 20'(r_hdr[239:224]);
        w_fold1 = 17'(w_sum[15:0]) + 17'(w_sum[19:16]);
        w_fold2 = 17'(w_fold1[15:0]) + 17'(w_fold1[16]);
        w_csum  = ~w_fold2[15:0];
    end
`endif

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_word[i] = r_hdr[511-64*i -: 64];
        end
`ifdef IPV4_CSUM_EN
        w_word[3][47:32] = w_csum;
`endif
        w_hdr_word = w_word[r_widx];
    end

    assign w_hb      = (r_hdr[15:0] == 16'h0000) ||
                       (r_hdr[15:0] == 16'hFFFF);
    assign w_w7      = (r_widx == 3'd7);
    assign w_tx_fire = r_tx_valid && tx_ready;
    assign w_pl_num  = r_plcnt + 1'b1;
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    // The first payload beat is taken while w7 transfers so the
    // header-to-payload boundary carries no bubble.
    always_comb begin
        w_pl_ready = 1'b0;
        case (r_state)
            S_HDR:     w_pl_ready = w_w7 && !w_hb && tx_ready;
            S_PAYLOAD: w_pl_ready = !(r_tx_valid && r_tx_last) &&
                                    (!r_tx_valid || tx_ready);
            S_DRAIN:   w_pl_ready = 1'b1;
            default:   w_pl_ready = 1'b0;
        endcase
    end

    assign w_pl_fire = pl_valid && w_pl_ready;
    assign w_trunc   = w_pl_fire && (r_state != S_DRAIN) &&
                       (w_pl_num == MAX_PL) && !pl_last;

    always_comb begin
        w_cur_last = 1'b0;
        case (r_state)
            S_HDR:     w_cur_last = w_w7 && w_hb;
            S_PAYLOAD: w_cur_last = r_tx_last;
            default:   w_cur_last = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_HDR;
                end
            end
            S_HDR: begin
                if (w_tx_fire && w_w7) begin
                    w_next = w_hb ? S_IDLE : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (w_tx_fire && r_tx_last) begin
                    w_next = r_trunc_pend ? S_DRAIN : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (pl_valid && pl_last) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hdr        <= '0;
            r_widx       <= '0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_tx_last    <= 1'b0;
            r_tx_keep    <= '0;
            r_cnt        <= '0;
            r_plcnt      <= '0;
            r_trunc_pend <= 1'b0;
            r_done       <= 1'b0;
            r_trunc      <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_trunc <= 1'b0;

            if (w_tx_fire && !w_cur_last) begin
                r_cnt <= w_cnt_inc;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_hdr        <= hdr_in;
                        r_widx       <= '0;
                        r_cnt        <= '0;
                        r_plcnt      <= '0;
                        r_tx_valid   <= 1'b1;
                        r_tx_last    <= 1'b0;
                        r_tx_keep    <= '0;
                        r_trunc_pend <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (w_tx_fire) begin
                        if (w_w7) begin
                            r_tx_valid <= 1'b0;
                            r_done     <= w_hb;
                        end else begin
                            r_widx <= r_widx + 3'd1;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (w_tx_fire) begin
                        r_tx_valid <= 1'b0;
                        if (r_tx_last) begin
                            r_tx_last <= 1'b0;
                            r_tx_keep <= '0;
                            r_done    <= !r_trunc_pend;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pl_valid && pl_last) begin
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (w_pl_fire && (r_state != S_DRAIN)) begin
                r_tx_data  <= pl_data;
                r_tx_valid <= 1'b1;
                r_plcnt    <= w_pl_num;
                if (w_trunc) begin
                    r_tx_last    <= 1'b1;
                    r_tx_keep    <= '0;
                    r_trunc      <= 1'b1;
                    r_trunc_pend <= 1'b1;
                end else begin
                    r_tx_last <= pl_last;
                    r_tx_keep <= pl_last ? pl_keep : 3'd0;
                end
            end
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign pl_ready    = w_pl_ready;
    assign tx_valid    = r_tx_valid;
    assign tx_data_net = !r_tx_valid ? 64'd0 :
                         (r_state == S_HDR) ? w_hdr_word : r_tx_data;
    assign tx_last     = r_tx_valid && w_cur_last;
    assign tx_keep     = (r_tx_valid && (r_state == S_PAYLOAD) && r_tx_last) ?
                         r_tx_keep : 3'd0;
    assign counterOut  = r_cnt;
    assign done        = r_done;
    assign trunc_err   = r_trunc;

endmodule

// File: tb/tb_moldudp64_tx_framer.sv
// Scoreboard bench for moldudp64_tx_framer: random frames against a frame-level model.
// Build with +define+IPV4_CSUM_EN to check the computed IPv4 checksum.
module tb_moldudp64_tx_framer;

    localparam int CNT_W = 7;
    localparam int MAXPL = 119;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [511:0]     hdr_in;
    logic             busy;
    logic [63:0]      pl_data;
    logic             pl_valid;
    logic             pl_ready;
    logic             pl_last;
    logic [2:0]       pl_keep;
    logic [63:0]      tx_data_net;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_last;
    logic [2:0]       tx_keep;
    logic [CNT_W-1:0] counterOut;
    logic             done;
    logic             trunc_err;

    moldudp64_tx_framer #(.CNT_W(CNT_W), .MAX_PL_WORDS(MAXPL)) dut (
        .clk(clk), .rst(rst), .start(start), .hdr_in(hdr_in), .busy(busy),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
        .pl_last(pl_last), .pl_keep(pl_keep), .tx_data_net(tx_data_net),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
        .tx_keep(tx_keep), .counterOut(counterOut), .done(done),
        .trunc_err(trunc_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]      d;
        logic             last;
        logic [2:0]       keep;
        logic [CNT_W-1:0] idx;
        logic             trunc;
    } beat_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_pass = 0;
    int    stall_pct = 0;
    bit    mon_en = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        $display("FAIL %s: got timeout expected event", nm);
    endtask

`ifdef IPV4_CSUM_EN
    function automatic logic [15:0] ip_csum(input logic [63:0] w[8]);
        logic [15:0] hw[9];
        int unsigned s;
        hw = '{w[2][63:48], w[2][47:32], w[2][31:16], w[2][15:0],
               w[3][63:48], w[3][31:16], w[3][15:0],
               w[4][63:48], w[4][47:32]};
        s = 0;
        foreach (hw[k]) s += hw[k];
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return ~s[15:0];
    endfunction
`endif

    // Frame-level reference: 8 header words, then up to MAXPL payload beats.
    task automatic model_push(input logic [511:0] h, input logic [63:0] pd[$],
                              input logic [2:0] kl);
        logic [63:0] w[8];
        beat_t b;
        bit hb;
        int n, ns;
        for (int i = 0; i < 8; i++) w[i] = h[511-64*i -: 64];
`ifdef IPV4_CSUM_EN
        w[3][47:32] = ip_csum(w);
`endif
        hb = (h[15:0] == 16'h0000) || (h[15:0] == 16'hFFFF);
        for (int i = 0; i < 8; i++) begin
            b.d = w[i]; b.last = (i == 7) && hb; b.keep = 3'd0;
            b.idx = CNT_W'(i); b.trunc = 1'b0;
            sb.push_back(b);
        end
        if (!hb) begin
            n = pd.size();
            ns = (n > MAXPL) ? MAXPL : n;
            for (int j = 0; j < ns; j++) begin
                b.d = pd[j];
                b.last = (j == ns - 1);
                b.keep = (j == n - 1) ? kl : 3'd0;
                b.trunc = (n > MAXPL) && (j == ns - 1);
                b.idx = (8 + j > 127) ? CNT_W'(127) : CNT_W'(8 + j);
                sb.push_back(b);
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        tx_ready = ($urandom_range(0, 99) >= stall_pct);
    end

    // Monitor: pops expectations on every tx transfer and checks done timing.
    bit          exp_done = 0;
    bit          seen_trunc = 0;
    bit          draining = 0;
    bit          hold_v = 0;
    logic [63:0] hold_d;
    beat_t       e;

    always @(negedge clk) begin
        if (!mon_en) begin
            exp_done = 0; seen_trunc = 0; draining = 0; hold_v = 0;
        end else begin
            if (exp_done || done) chk("done", done, exp_done);
            exp_done = 0;
            if (trunc_err) seen_trunc = 1;
            if (hold_v) chk("hold", {tx_valid, tx_data_net}, {1'b1, hold_d});
            hold_v = 0;
            if (tx_valid && !tx_ready) begin
                hold_v = 1;
                hold_d = tx_data_net;
            end
            if (tx_valid && tx_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", tx_data_net, 64'd0);
                    if (tx_data_net == 64'd0) fail_now("unexpected_beat");
                end else begin
                    e = sb.pop_front();
                    chk("beat", {tx_data_net, tx_last, tx_keep, counterOut, seen_trunc},
                        {e.d, e.last, e.keep, e.idx, e.trunc});
                    if (e.last) begin
                        if (e.trunc) draining = 1;
                        else exp_done = 1;
                    end
                end
                seen_trunc = 0;
            end
            if (draining && pl_valid && pl_ready && pl_last) begin
                exp_done = 1;
                draining = 0;
            end
        end
    end

    task automatic wait_idle();
        int tmo = 0;
        while (busy && tmo < 5000) begin
            @(posedge clk); #1; tmo++;
        end
        if (tmo >= 5000) fail_now("wait_idle");
    endtask

    task automatic send_frame(input logic [15:0] mc, input int n,
                              input logic [2:0] kl, input int gap,
                              input bit inj, input logic [511:0] hfix,
                              input bit use_fix);
        logic [511:0] h;
        logic [63:0] pd[$];
        bit hb, acc;
        int tmo;
        if (use_fix) h = hfix;
        else for (int i = 0; i < 16; i++) h[32*i +: 32] = $urandom;
        h[15:0] = mc;
        hb = (mc == 16'h0000) || (mc == 16'hFFFF);
        if (!hb) for (int j = 0; j < n; j++) pd.push_back({$urandom, $urandom});
        wait_idle();
        model_push(h, pd, kl);
        start = 1; hdr_in = h;
        @(posedge clk); #1;
        start = 0;
        if (inj) begin
            repeat (2) @(posedge clk);
            #1; start = 1; hdr_in = ~h;
            @(posedge clk); #1;
            start = 0;
        end
        for (int j = 0; j < pd.size(); j++) begin
            pl_data = pd[j];
            pl_last = (j == pd.size() - 1);
            pl_keep = pl_last ? kl : 3'($urandom_range(0, 7));
            acc = 0; tmo = 0;
            while (!acc) begin
                pl_valid = ($urandom_range(0, 99) >= gap);
                @(negedge clk);
                acc = pl_valid && pl_ready;
                @(posedge clk); #1;
                tmo++;
                if (!acc && tmo > 3000) begin
                    fail_now("pl_accept");
                    pl_valid = 0;
                    return;
                end
            end
        end
        pl_valid = 0; pl_last = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] hf;
        int tmo;
        rst = 0; start = 0; hdr_in = '0;
        pl_data = '0; pl_valid = 0; pl_last = 0; pl_keep = '0;
        #1;
        chk("rst_tx", {tx_valid, tx_data_net, tx_last, tx_keep}, '0);
        chk("rst_ctl", {busy, done, trunc_err, counterOut, pl_ready}, '0);
        repeat (3) @(posedge clk);
        #1; rst = 1; mon_en = 1;

        stall_pct = 0;
        send_frame(16'h0000, 0, 3'd0, 0, 0, '0, 0);
        send_frame(16'hFFFF, 0, 3'd0, 0, 0, '0, 0);
        send_frame(16'h0002, 2, 3'd3, 0, 0, '0, 0);
        stall_pct = 40;
        send_frame(16'h0005, 6, 3'd5, 20, 1, '0, 0);
        stall_pct = 10;
        send_frame(16'h0007, 130, 3'd0, 10, 0, '0, 0);
        send_frame(16'h0003, MAXPL, 3'd4, 0, 0, '0, 0);

        hf = '0;
        hf[383:320] = 64'h4500_0073_0000_4000;
        hf[319:256] = 64'h4011_1234_c0a8_0001;
        hf[255:192] = 64'hc0a8_00c7_1234_5678;
        stall_pct = 0;
        send_frame(16'h0001, 1, 3'd6, 0, 0, hf, 1);

        for (int f = 0; f < 20; f++) begin
            stall_pct = $urandom_range(0, 50);
            send_frame(($urandom_range(0, 7) == 0) ? 16'h0000 :
                       16'($urandom_range(1, 16'hFFFE)),
                       $urandom_range(1, 20), 3'($urandom_range(0, 7)),
                       $urandom_range(0, 40), 0, '0, 0);
        end

        stall_pct = 0;
        send_frame(16'h0000, 0, 3'd0, 0, 0, '0, 0);
        wait_idle();
        stall_pct = 0;
        for (int i = 0; i < 16; i++) hf[32*i +: 32] = $urandom;
        hf[15:0] = 16'h0000;
        begin
            logic [63:0] none[$];
            model_push(hf, none, 3'd0);
        end
        start = 1; hdr_in = hf;
        @(posedge clk); #1; start = 0;
        tmo = 0;
        while (!(tx_valid && counterOut == 7'd5) && tmo < 100) begin
            @(negedge clk); tmo++;
        end
        if (tmo >= 100) fail_now("reach_beat5");
        mon_en = 0;
        rst = 0;
        #1;
        chk("midrst_tx", {tx_valid, tx_data_net, tx_last, tx_keep}, '0);
        chk("midrst_ctl", {busy, done, trunc_err, counterOut, pl_ready}, '0);
        sb.delete();
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1; mon_en = 1;
        send_frame(16'h0009, 3, 3'd2, 0, 0, '0, 0);

        tmo = 0;
        while ((sb.size() != 0 || busy) && tmo < 5000) begin
            @(posedge clk); #1; tmo++;
        end
        if (tmo >= 5000) fail_now("final_drain");
        repeat (3) @(posedge clk);
        chk("sb_empty", 128'(sb.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
